// File: rtl/operand_loader.sv
// Operand entry stage: debounced load/restart buttons assemble x then y, one byte per press, LSB first.
// Optional feature macro: OPLOAD_DIVZERO_CHK_EN (registered y==0 flag when ready rises).

module operand_loader_btn #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic clear,
  input  logic btn,
  output logic pulse
);

  logic [1:0]       sync;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  // The accepted level flips only after the synced level has disagreed for a full run of cycles.
  always_ff @(posedge clk) begin
    if (clear) begin
      sync    <= 2'b00;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync    <= {sync[0], btn};
      level_d <= level;
      if (sync[1] != level) begin
        if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign pulse = level & ~level_d;

endmodule

module operand_loader #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        btn_load,
  input  logic        btn_restart,
  input  logic [7:0]  in_data,
  output logic [31:0] x,
  output logic [31:0] y,
  output logic        ready,
  output logic [2:0]  entry_idx,
  output logic        div_zero
);

  typedef enum logic {ENTRY, READY} state_t;

  state_t state;
  logic   ld_p;
  logic   rs_p;

  operand_loader_btn #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_load_btn (
    .clk  (clk),
    .clear(clear),
    .btn  (btn_load),
    .pulse(ld_p)
  );

  operand_loader_btn #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_restart_btn (
    .clk  (clk),
    .clear(clear),
    .btn  (btn_restart),
    .pulse(rs_p)
  );

  // Restart takes priority over load; loads are ignored once both operands are complete.
  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= ENTRY;
      x         <= '0;
      y         <= '0;
      ready     <= 1'b0;
      entry_idx <= 3'd0;
    end else if (rs_p) begin
      state     <= ENTRY;
      x         <= '0;
      y         <= '0;
      ready     <= 1'b0;
      entry_idx <= 3'd0;
    end else if (ld_p && state == ENTRY) begin
      if (!entry_idx[2])
        x[{entry_idx[1:0], 3'b000} +: 8] <= in_data;
      else
        y[{entry_idx[1:0], 3'b000} +: 8] <= in_data;
      if (entry_idx == 3'd7) begin
        state <= READY;
        ready <= 1'b1;
      end else begin
        entry_idx <= entry_idx + 3'd1;
      end
    end
  end

`ifdef OPLOAD_DIVZERO_CHK_EN
  // The final write lands in y[31:24], so the compare uses the incoming byte for that lane.
  always_ff @(posedge clk) begin
    if (clear || rs_p)
      div_zero <= 1'b0;
    else if (ld_p && state == ENTRY && entry_idx == 3'd7)
      div_zero <= ({in_data, y[23:0]} == 32'd0);
  end
`else
  assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_operand_loader.sv
// Scoreboard bench for operand_loader with a short debounce window; expectations are pushed by
// the stimulus and popped by a monitor whenever the outputs change or a quiet-state check is requested.

module tb_operand_loader;

  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic        btn_load = 1'b0;
  logic        btn_restart = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic [31:0] x;
  logic [31:0] y;
  logic        ready;
  logic [2:0]  entry_idx;
  logic        div_zero;

`ifdef OPLOAD_DIVZERO_CHK_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic        rdy;
    logic [2:0]  idx;
    logic        dz;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    req_cnt = 0;
  int    seen_cnt = 0;
  bit    mon_en = 1'b0;
  logic [68:0] prev;

  operand_loader #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (20)
  ) dut (
    .clk        (clk),
    .clear      (clear),
    .btn_load   (btn_load),
    .btn_restart(btn_restart),
    .in_data    (in_data),
    .x          (x),
    .y          (y),
    .ready      (ready),
    .entry_idx  (entry_idx),
    .div_zero   (div_zero)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pushExp(input string nm, input logic [31:0] ex, input logic [31:0] ey,
                         input logic [2:0] eidx, input logic erdy, input logic edz);
    exp_t e;
    e.x   = ex;
    e.y   = ey;
    e.rdy = erdy;
    e.idx = eidx;
    e.dz  = edz & DZ_EN;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Press (and release) the selected buttons; push the hand-computed result first when one is expected.
  task automatic applyStimulus(input string nm, input logic ld, input logic rs, input bit bounce,
                               input logic [7:0] d, input bit push,
                               input logic [31:0] ex, input logic [31:0] ey,
                               input logic [2:0] eidx, input logic erdy, input logic edz);
    in_data = d;
    if (push) pushExp(nm, ex, ey, eidx, erdy, edz);
    if (bounce) begin
      repeat (3) begin
        btn_load = ld; btn_restart = rs;
        tick(1);
        btn_load = 1'b0; btn_restart = 1'b0;
        tick(1);
      end
    end
    btn_load = ld; btn_restart = rs;
    tick(10);
    if (bounce) begin
      repeat (3) begin
        btn_load = 1'b0; btn_restart = 1'b0;
        tick(1);
        btn_load = ld; btn_restart = rs;
        tick(1);
      end
    end
    btn_load = 1'b0; btn_restart = 1'b0;
    tick(10);
  endtask

  task automatic ld(input logic [7:0] d, input logic [31:0] ex, input logic [31:0] ey,
                    input logic [2:0] eidx, input logic erdy, input logic edz);
    applyStimulus($sformatf("load_%02h_idx%0d", d, eidx), 1'b1, 1'b0, 1'b0, d, 1'b1,
                  ex, ey, eidx, erdy, edz);
  endtask

  task automatic restart(input string nm);
    applyStimulus(nm, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic requestCheck(input string nm, input logic [31:0] ex, input logic [31:0] ey,
                              input logic [2:0] eidx, input logic erdy, input logic edz);
    pushExp(nm, ex, ey, eidx, erdy, edz);
    req_cnt++;
    tick(3);
  endtask

  task automatic checkOutput();
    exp_t  e;
    string nm;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL unexpected_change: x=%h y=%h rdy=%b idx=%0d dz=%b, none expected",
               x, y, ready, entry_idx, div_zero);
    end else begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (x !== e.x || y !== e.y || ready !== e.rdy || entry_idx !== e.idx || div_zero !== e.dz) begin
        miscompares++;
        $display("[TB] FAIL %s: got x=%h y=%h rdy=%b idx=%0d dz=%b, want x=%h y=%h rdy=%b idx=%0d dz=%b",
                 nm, x, y, ready, entry_idx, div_zero, e.x, e.y, e.rdy, e.idx, e.dz);
      end
    end
  endtask

  // Monitor: every output change, or an explicit quiet-state request, consumes one expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && (({x, y, ready, entry_idx, div_zero} != prev) || (req_cnt != seen_cnt))) begin
        seen_cnt = req_cnt;
        checkOutput();
      end
      prev = {x, y, ready, entry_idx, div_zero};
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    clear = 1'b1;
    tick(2);
    clear = 1'b0;
    tick(1);
    @(negedge clk);
    prev   = {x, y, ready, entry_idx, div_zero};
    mon_en = 1'b1;
    #1;
    requestCheck("reset_state", 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);

    ld(8'h78, 32'h00000078, 32'h00000000, 3'd1, 1'b0, 1'b0);
    ld(8'h56, 32'h00005678, 32'h00000000, 3'd2, 1'b0, 1'b0);
    ld(8'h34, 32'h00345678, 32'h00000000, 3'd3, 1'b0, 1'b0);
    ld(8'h12, 32'h12345678, 32'h00000000, 3'd4, 1'b0, 1'b0);
    ld(8'h04, 32'h12345678, 32'h00000004, 3'd5, 1'b0, 1'b0);
    ld(8'h03, 32'h12345678, 32'h00000304, 3'd6, 1'b0, 1'b0);
    ld(8'h02, 32'h12345678, 32'h00020304, 3'd7, 1'b0, 1'b0);
    ld(8'h01, 32'h12345678, 32'h01020304, 3'd7, 1'b1, 1'b0);

    applyStimulus("load_in_ready", 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
    requestCheck("held_in_ready", 32'h12345678, 32'h01020304, 3'd7, 1'b1, 1'b0);
    restart("restart_from_ready");

    applyStimulus("bounced_load", 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1,
                  32'h000000A5, 32'h0, 3'd1, 1'b0, 1'b0);
    requestCheck("bounce_single_write", 32'h000000A5, 32'h0, 3'd1, 1'b0, 1'b0);
    ld(8'h11, 32'h000011A5, 32'h0, 3'd2, 1'b0, 1'b0);
    ld(8'h22, 32'h002211A5, 32'h0, 3'd3, 1'b0, 1'b0);
    applyStimulus("load_and_restart", 1'b1, 1'b1, 1'b0, 8'h99, 1'b1,
                  32'h0, 32'h0, 3'd0, 1'b0, 1'b0);

    ld(8'h01, 32'h00000001, 32'h0, 3'd1, 1'b0, 1'b0);
    ld(8'h02, 32'h00000201, 32'h0, 3'd2, 1'b0, 1'b0);
    ld(8'h03, 32'h00030201, 32'h0, 3'd3, 1'b0, 1'b0);
    ld(8'h04, 32'h04030201, 32'h0, 3'd4, 1'b0, 1'b0);
    ld(8'h05, 32'h04030201, 32'h00000005, 3'd5, 1'b0, 1'b0);
    pushExp("clear_at_idx5", 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(5);

    ld(8'h05, 32'h00000005, 32'h0, 3'd1, 1'b0, 1'b0);
    ld(8'h00, 32'h00000005, 32'h0, 3'd2, 1'b0, 1'b0);
    ld(8'h00, 32'h00000005, 32'h0, 3'd3, 1'b0, 1'b0);
    ld(8'h00, 32'h00000005, 32'h0, 3'd4, 1'b0, 1'b0);
    ld(8'h00, 32'h00000005, 32'h0, 3'd5, 1'b0, 1'b0);
    ld(8'h00, 32'h00000005, 32'h0, 3'd6, 1'b0, 1'b0);
    ld(8'h00, 32'h00000005, 32'h0, 3'd7, 1'b0, 1'b0);
    ld(8'h00, 32'h00000005, 32'h0, 3'd7, 1'b1, 1'b1);
    restart("restart_after_divzero");

    ld(8'h05, 32'h00000005, 32'h0, 3'd1, 1'b0, 1'b0);
    ld(8'h00, 32'h00000005, 32'h0, 3'd2, 1'b0, 1'b0);
    ld(8'h00, 32'h00000005, 32'h0, 3'd3, 1'b0, 1'b0);
    ld(8'h00, 32'h00000005, 32'h0, 3'd4, 1'b0, 1'b0);
    ld(8'h00, 32'h00000005, 32'h00000000, 3'd5, 1'b0, 1'b0);
    ld(8'h01, 32'h00000005, 32'h00000100, 3'd6, 1'b0, 1'b0);
    ld(8'h00, 32'h00000005, 32'h00000100, 3'd7, 1'b0, 1'b0);
    ld(8'h00, 32'h00000005, 32'h00000100, 3'd7, 1'b1, 1'b0);

    tick(20);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL missing_outputs: %0d expectations left unconsumed, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
